// File: rtl/level_object_window_pkg.sv
// rtl/level_object_window_pkg.sv - shared object layout, type codes, FSM states and helpers
package level_pkg;

  localparam int ID_W    = 10;
  localparam int TYPE_W  = 10;
  localparam int COORD_W = 16;
  localparam int OBJ_W   = ID_W + TYPE_W + 4 * COORD_W + 1;

  // Bit offsets of each field inside a packed ROM word
  localparam int OFF_COLL = 0;
  localparam int OFF_H    = OFF_COLL + 1;
  localparam int OFF_W    = OFF_H + COORD_W;
  localparam int OFF_Y    = OFF_W + COORD_W;
  localparam int OFF_X    = OFF_Y + COORD_W;
  localparam int OFF_TYPE = OFF_X + COORD_W;
  localparam int OFF_ID   = OFF_TYPE + TYPE_W;

  localparam logic [TYPE_W-1:0] TYPE_GROUND = 10'd101;
  localparam logic [TYPE_W-1:0] TYPE_BRICK  = 10'd102;
  localparam logic [TYPE_W-1:0] TYPE_COIN   = 10'd103;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [TYPE_W-1:0]  kind;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    logic               coll_en;
  } obj_t;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/level_object_window_if.sv
// rtl/level_object_window_if.sv - level ROM bus and slot-kill handshake
interface level_object_window_if #(
  parameter int NUM_OBJ = 64,
  parameter int WIN     = 20
);
  import level_pkg::*;

  localparam int AW = clog2(NUM_OBJ);
  localparam int SW = clog2(WIN);

  logic [AW-1:0]    tbl_addr;
  logic [OBJ_W-1:0] tbl_data;
  logic             kill_req;
  logic [SW-1:0]    kill_slot;
  logic             kill_ack;

  modport master (
    output tbl_addr,
    output kill_ack,
    input  tbl_data,
    input  kill_req,
    input  kill_slot
  );

  modport slave (
    input  tbl_addr,
    input  kill_ack,
    output tbl_data,
    output kill_req,
    output kill_slot
  );

endinterface

// File: rtl/level_object_window_queue.sv
// rtl/level_object_window_queue.sv - WIN-deep shift queue with append, pop-front and coll_en clear
module obj_window_queue
  import level_pkg::*;
#(
  parameter int WIN = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   append,
  input  obj_t                   append_data,
  input  logic                   pop,
  input  logic                   kill,
  input  logic [clog2(WIN)-1:0]  kill_idx,
  output obj_t [WIN-1:0]         slot,
  output logic [clog2(WIN):0]    count,
  output logic [WIN-1:0]         valid
);

  localparam int SW = clog2(WIN);

  // Queue storage: at most one operation per clock, the controller arbitrates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot  <= '0;
      count <= '0;
    end else if (pop) begin
      for (int i = 0; i < WIN - 1; i++) slot[i] <= slot[i+1];
      slot[WIN-1] <= '0;
      count       <= count - 1'b1;
    end else if (append) begin
      slot[count[SW-1:0]] <= append_data;
      count               <= count + 1'b1;
    end else if (kill) begin
      slot[kill_idx].coll_en <= 1'b0;
    end
  end

  // Occupied slots are always the contiguous run 0..count-1
  always_comb begin
    valid = '0;
    for (int i = 0; i < WIN; i++) valid[i] = ((SW + 1)'(i) < count);
  end

endmodule

// File: rtl/level_object_window.sv
// rtl/level_object_window.sv - level-map object window: FSM, cam latch, ROM addressing, output packing
module level_object_window
  import level_pkg::*;
#(
  parameter int NUM_OBJ  = 64,
  parameter int WIN      = 20,
  parameter int SCREEN_W = 640,
  parameter int MARGIN   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COORD_W-1:0]       cam_x,
  level_object_window_if.master    bus,
  output logic [WIN*ID_W-1:0]      win_id,
  output logic [WIN*TYPE_W-1:0]    win_type,
  output logic [WIN*2*COORD_W-1:0] win_coord,
  output logic [WIN*2*COORD_W-1:0] win_size,
  output logic [WIN-1:0]           win_coll_en,
  output logic [WIN-1:0]           win_valid,
  output logic [clog2(WIN):0]      win_count,
  output logic                     level_done
);

  localparam int AW = clog2(NUM_OBJ);
  localparam int SW = clog2(WIN);
  localparam logic [AW:0]      LAST_PTR = (AW + 1)'(NUM_OBJ);
  localparam logic [SW:0]      FULL     = (SW + 1)'(WIN);
  localparam logic [COORD_W:0] REACH    = (COORD_W + 1)'(SCREEN_W + MARGIN);

  state_t             state, state_nx;
  logic [COORD_W-1:0] cam_q;
  logic [AW:0]        next_ptr;
  logic               pend_vld;
  logic [COORD_W-1:0] pend_x;
  logic               kill_ack_q;

  obj_t               rd_obj;
  obj_t [WIN-1:0]     q_slot;
  logic [SW:0]        q_count;
  logic [WIN-1:0]     q_valid;
  logic               q_append, q_pop, q_kill, set_pend, ack_nx;
  logic [COORD_W:0]   reach_lim;
  logic               rd_fits, pend_fits, can_retire, can_fetch, kill_hit;

  // All range compares run one bit wider than a coordinate so x+w and cam+reach never wrap
  assign rd_obj     = bus.tbl_data;
  assign reach_lim  = {1'b0, cam_q} + REACH;
  assign rd_fits    = ({1'b0, rd_obj.x} <= reach_lim);
  assign pend_fits  = ({1'b0, pend_x} <= reach_lim);
  assign can_retire = q_valid[0] &&
                      (({1'b0, q_slot[0].x} + {1'b0, q_slot[0].w}) < {1'b0, cam_q});
  // A rejected entry parks its x so RUN stays idle (and can serve kills) until cam catches up
  assign can_fetch  = (q_count < FULL) && (next_ptr < LAST_PTR) && (!pend_vld || pend_fits);
  assign kill_hit   = ({1'b0, bus.kill_slot} < q_count);

  assign bus.tbl_addr = next_ptr[AW-1:0];
  assign bus.kill_ack = kill_ack_q;

  // Camera latch only moves forward; backward scroll requests are ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cam_q <= '0;
    else if (cam_x >= cam_q) cam_q <= cam_x;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_FILL;
    else      state <= state_nx;
  end

  // Next state and queue commands: retire beats fetch beats kill
  always_comb begin
    state_nx = state;
    q_append = 1'b0;
    q_pop    = 1'b0;
    q_kill   = 1'b0;
    set_pend = 1'b0;
    ack_nx   = 1'b0;
    case (state)
      ST_FILL: state_nx = ST_WAIT;
      ST_WAIT: begin
        if (rd_fits) q_append = 1'b1;
        else         set_pend = 1'b1;
        state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (can_retire)     q_pop = 1'b1;
        else if (can_fetch) state_nx = ST_FILL;
        else if (bus.kill_req && !kill_ack_q) begin
          ack_nx = 1'b1;
          q_kill = kill_hit;
        end
      end
      default: state_nx = ST_FILL;
    endcase
  end

  // Table pointer, parked out-of-reach entry and kill acknowledge pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      next_ptr   <= '0;
      pend_vld   <= 1'b0;
      pend_x     <= '0;
      kill_ack_q <= 1'b0;
    end else begin
      kill_ack_q <= ack_nx;
      if (q_append) begin
        next_ptr <= next_ptr + 1'b1;
        pend_vld <= 1'b0;
      end else if (set_pend) begin
        pend_vld <= 1'b1;
        pend_x   <= rd_obj.x;
      end
    end
  end

  obj_window_queue #(.WIN(WIN)) u_queue (
    .clk         (clk),
    .rst         (rst),
    .append      (q_append),
    .append_data (rd_obj),
    .pop         (q_pop),
    .kill        (q_kill),
    .kill_idx    (bus.kill_slot),
    .slot        (q_slot),
    .count       (q_count),
    .valid       (q_valid)
  );

  // Registered window outputs; screen_x tracks the latched cam every clock, empty slots read zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_id      <= '0;
      win_type    <= '0;
      win_coord   <= '0;
      win_size    <= '0;
      win_coll_en <= '0;
      win_valid   <= '0;
      win_count   <= '0;
      level_done  <= 1'b0;
    end else begin
      for (int i = 0; i < WIN; i++) begin
        if (q_valid[i]) begin
          win_id[i*ID_W +: ID_W]           <= q_slot[i].id;
          win_type[i*TYPE_W +: TYPE_W]     <= q_slot[i].kind;
          win_coord[i*2*COORD_W +: 2*COORD_W] <= {q_slot[i].x - cam_q, q_slot[i].y};
          win_size[i*2*COORD_W +: 2*COORD_W]  <= {q_slot[i].w, q_slot[i].h};
          win_coll_en[i]                   <= q_slot[i].coll_en;
        end else begin
          win_id[i*ID_W +: ID_W]           <= '0;
          win_type[i*TYPE_W +: TYPE_W]     <= '0;
          win_coord[i*2*COORD_W +: 2*COORD_W] <= '0;
          win_size[i*2*COORD_W +: 2*COORD_W]  <= '0;
          win_coll_en[i]                   <= 1'b0;
        end
      end
      win_valid  <= q_valid;
      win_count  <= q_count;
      level_done <= (next_ptr == LAST_PTR) && (q_count == '0);
    end
  end

endmodule

// File: tb/tb_level_object_window.sv
// tb/tb_level_object_window.sv - self-checking bench for level_object_window
module tb_level_object_window;
  import level_pkg::*;

  localparam int NUM_OBJ  = 32;
  localparam int WIN      = 20;
  localparam int SCREEN_W = 640;
  localparam int MARGIN   = 32;
  localparam int SETTLE   = 300;
  localparam int CWID     = clog2(WIN) + 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [COORD_W-1:0]       cam_x = '0;
  logic [WIN*ID_W-1:0]      win_id;
  logic [WIN*TYPE_W-1:0]    win_type;
  logic [WIN*2*COORD_W-1:0] win_coord;
  logic [WIN*2*COORD_W-1:0] win_size;
  logic [WIN-1:0]           win_coll_en;
  logic [WIN-1:0]           win_valid;
  logic [CWID-1:0]          win_count;
  logic                     level_done;

  level_object_window_if #(.NUM_OBJ(NUM_OBJ), .WIN(WIN)) ifc ();

  level_object_window #(
    .NUM_OBJ(NUM_OBJ), .WIN(WIN), .SCREEN_W(SCREEN_W), .MARGIN(MARGIN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cam_x       (cam_x),
    .bus         (ifc),
    .win_id      (win_id),
    .win_type    (win_type),
    .win_coord   (win_coord),
    .win_size    (win_size),
    .win_coll_en (win_coll_en),
    .win_valid   (win_valid),
    .win_count   (win_count),
    .level_done  (level_done)
  );

  always #5 clk = ~clk;

  obj_t rom [NUM_OBJ];

  always @(posedge clk) ifc.tbl_data <= rom[ifc.tbl_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the window is the table index range [m_head, m_ptr)
  int m_head, m_ptr, m_cam;
  bit m_killed [NUM_OBJ];

  task automatic m_reset();
    m_head = 0;
    m_ptr  = 0;
    m_cam  = 0;
    for (int i = 0; i < NUM_OBJ; i++) m_killed[i] = 1'b0;
  endtask

  task automatic m_settle();
    forever begin
      if (m_ptr > m_head && (int'(rom[m_head].x) + int'(rom[m_head].w)) < m_cam)
        m_head++;
      else if ((m_ptr - m_head) < WIN && m_ptr < NUM_OBJ &&
               int'(rom[m_ptr].x) <= m_cam + SCREEN_W + MARGIN)
        m_ptr++;
      else
        break;
    end
  endtask

  task automatic compare_all(input string tag);
    int   cnt;
    obj_t e;
    bit   v;
    cnt = m_ptr - m_head;
    check($sformatf("%s.count", tag), 64'(win_count), 64'(cnt));
    check($sformatf("%s.done", tag), 64'(level_done), 64'(m_ptr == NUM_OBJ && cnt == 0));
    for (int i = 0; i < WIN; i++) begin
      v = (i < cnt);
      e = '0;
      if (v) e = rom[m_head + i];
      check($sformatf("%s.s%0d.valid", tag, i), 64'(win_valid[i]), 64'(v));
      check($sformatf("%s.s%0d.id", tag, i), 64'(win_id[i*ID_W +: ID_W]), 64'(e.id));
      check($sformatf("%s.s%0d.type", tag, i), 64'(win_type[i*TYPE_W +: TYPE_W]), 64'(e.kind));
      check($sformatf("%s.s%0d.coord", tag, i), 64'(win_coord[i*32 +: 32]),
            v ? 64'({e.x - 16'(m_cam), e.y}) : 64'(0));
      check($sformatf("%s.s%0d.size", tag, i), 64'(win_size[i*32 +: 32]), 64'({e.w, e.h}));
      check($sformatf("%s.s%0d.coll", tag, i), 64'(win_coll_en[i]),
            64'(v && e.coll_en && !(v && m_killed[m_head + i])));
    end
  endtask

  task automatic set_cam(input int v);
    @(negedge clk);
    cam_x = 16'(v);
    if (v > m_cam) m_cam = v;
    m_settle();
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic do_kill(input int s);
    int n;
    int cnt;
    @(negedge clk);
    ifc.kill_slot = 5'(s);
    ifc.kill_req  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifc.kill_ack && n < 10);
    check($sformatf("kill%0d.ack_latency", s), 64'(n), 64'(1));
    ifc.kill_req = 1'b0;
    cnt = m_ptr - m_head;
    if (s < cnt) m_killed[m_head + s] = 1'b1;
    @(negedge clk);
    check($sformatf("kill%0d.ack_pulse", s), 64'(ifc.kill_ack), 64'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".count"}, 64'(win_count), 64'(0));
    check({tag, ".done"}, 64'(level_done), 64'(0));
    check({tag, ".valid"}, 64'(|win_valid), 64'(0));
    check({tag, ".id"}, 64'(|win_id), 64'(0));
    check({tag, ".coord"}, 64'(|win_coord), 64'(0));
    check({tag, ".coll"}, 64'(|win_coll_en), 64'(0));
    check({tag, ".addr"}, 64'(ifc.tbl_addr), 64'(0));
    check({tag, ".ack"}, 64'(ifc.kill_ack), 64'(0));
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst          = 1'b0;
    cam_x        = '0;
    ifc.kill_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_reset();
  endtask

  task automatic load_table_a();
    int xs [6] = '{100, 200, 300, 550, 600, 850};
    for (int i = 0; i < NUM_OBJ; i++) begin
      rom[i].id      = 10'(i);
      rom[i].kind    = (i % 3 == 0) ? TYPE_GROUND : (i % 3 == 1) ? TYPE_BRICK : TYPE_COIN;
      rom[i].x       = (i < 6) ? 16'(xs[i]) : 16'(2000 + i * 10);
      rom[i].y       = 16'd450;
      rom[i].w       = (i < 6) ? 16'd300 : 16'd20;
      rom[i].h       = 16'd16;
      rom[i].coll_en = 1'b1;
    end
  endtask

  task automatic load_table_b();
    for (int i = 0; i < NUM_OBJ; i++) begin
      rom[i].id      = 10'(i);
      rom[i].kind    = TYPE_BRICK;
      rom[i].x       = 16'(i * 20);
      rom[i].y       = 16'(100 + i);
      rom[i].w       = (i == 0) ? 16'd10 : 16'd1000;
      rom[i].h       = 16'd8;
      rom[i].coll_en = 1'b1;
    end
  endtask

  task automatic load_table_random();
    int xacc;
    xacc = 0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      xacc += $urandom_range(0, 60);
      rom[i].id = 10'(i);
      case ($urandom_range(0, 2))
        0:       rom[i].kind = TYPE_GROUND;
        1:       rom[i].kind = TYPE_BRICK;
        default: rom[i].kind = TYPE_COIN;
      endcase
      rom[i].x       = 16'(xacc);
      rom[i].y       = 16'($urandom);
      rom[i].w       = 16'($urandom_range(0, 200));
      rom[i].h       = 16'($urandom_range(1, 64));
      rom[i].coll_en = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    ifc.kill_req  = 1'b0;
    ifc.kill_slot = '0;

    // Reset state and first fill of the six-object level
    load_table_a();
    m_reset();
    #1;
    check_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    m_settle();
    repeat (SETTLE) @(negedge clk);
    compare_all("fill6");
    check("fill6.count_lit", 64'(win_count), 64'(5));
    check("fill6.slot0_coord", 64'(win_coord[31:0]), 64'({16'd100, 16'd450}));
    check("fill6.coll_lit", 64'(win_coll_en[4:0]), 64'(5'h1F));

    // Right-edge retire boundary: end == cam is kept, end < cam retires
    set_cam(400);
    compare_all("cam400");
    @(negedge clk);
    cam_x = 16'd401;
    m_cam = 401;
    repeat (3) @(negedge clk);
    check("cam401.retire_fast", 64'(win_id[ID_W-1:0]), 64'(1));
    m_settle();
    repeat (SETTLE) @(negedge clk);
    compare_all("cam401");
    check("cam401.count_lit", 64'(win_count), 64'(5));

    // Kill an in-range slot, then an out-of-range slot
    do_kill(2);
    compare_all("kill2");
    check("kill2.coll_lit", 64'(win_coll_en[2]), 64'(0));
    check("kill2.valid_lit", 64'(win_valid[2]), 64'(1));
    do_kill(25);
    compare_all("kill25");

    // Backward camera move is ignored
    set_cam(500);
    set_cam(300);
    compare_all("cam_back");
    check("cam_back.screen_x", 64'(win_coord[2*32+16 +: 16]), 64'(50));

    // Reset in the middle of a fill, then saturate the window
    load_table_b();
    reset_dut();
    repeat (13) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_zero("midrst");
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    m_settle();
    repeat (SETTLE) @(negedge clk);
    compare_all("full");
    check("full.count_lit", 64'(win_count), 64'(20));
    check("full.slot19_id", 64'(win_id[19*ID_W +: ID_W]), 64'(19));
    set_cam(11);
    compare_all("full_retire");
    check("full_retire.slot19_id", 64'(win_id[19*ID_W +: ID_W]), 64'(20));

    // Randomized level with random camera steps and kills, then drain
    load_table_random();
    reset_dut();
    m_settle();
    repeat (SETTLE) @(negedge clk);
    compare_all("rnd_fill");
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0, 1: set_cam(m_cam + int'($urandom_range(0, 150)));
        2: begin
          if (m_cam > 100) set_cam(m_cam - int'($urandom_range(1, 100)));
          else             set_cam(m_cam + 10);
        end
        default: do_kill(int'($urandom_range(0, 24)));
      endcase
      compare_all($sformatf("rnd%0d", it));
    end
    set_cam(65000);
    compare_all("drain");
    check("drain.done_lit", 64'(level_done), 64'(1));
    check("drain.count_lit", 64'(win_count), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
